// File: rtl/vector_writeback_sequencer.sv
// Write-back sequencer: drains one captured vector result into the register file
// in LANES-wide beats, applying vl tail handling and the optional execution mask.
module vector_writeback_sequencer #(
  parameter int VECTOR_MASK_LENGTH   = 8,
  parameter int ELEMENT_WIDTH        = 32,
  parameter int LANES                = 2,
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int TAIL_AGNOSTIC        = 0
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        request_valid,
  output logic                                        request_ready,
  input  logic [REGISTER_INDEX_WIDTH-1:0]             request_destination,
  input  logic [$clog2(VECTOR_MASK_LENGTH):0]         request_vector_length,
  input  logic                                        request_mask_enable,
  input  logic [VECTOR_MASK_LENGTH-1:0]               request_mask,
  input  logic [VECTOR_MASK_LENGTH*ELEMENT_WIDTH-1:0] request_data,
  output logic                                        write_valid,
  input  logic                                        write_ready,
  output logic [REGISTER_INDEX_WIDTH-1:0]             write_destination,
  output logic [((VECTOR_MASK_LENGTH/LANES) > 1 ? $clog2(VECTOR_MASK_LENGTH/LANES) : 1)-1:0] write_beat_index,
  output logic [LANES*ELEMENT_WIDTH-1:0]              write_data,
  output logic [LANES-1:0]                            write_element_enable,
  output logic                                        complete_valid,
  output logic [REGISTER_INDEX_WIDTH-1:0]             complete_destination
);

  localparam int VL_W   = $clog2(VECTOR_MASK_LENGTH) + 1;
  localparam int BEATS  = VECTOR_MASK_LENGTH / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW     = ELEMENT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_COMPLETE
  } state_t;

  state_t                                r_state;
  state_t                                w_next_state;
  logic [BEAT_W-1:0]                     r_beat;
  logic [REGISTER_INDEX_WIDTH-1:0]       r_dest;
  logic [VL_W-1:0]                       r_vl;
  logic                                  r_mask_en;
  logic [VECTOR_MASK_LENGTH-1:0]         r_mask;
  logic [VECTOR_MASK_LENGTH*EW-1:0]      r_data;
  logic [BEAT_W-1:0]                     w_last_beat;
  logic                                  w_is_last;
  logic                                  w_accept;
  logic [VL_W-1:0]                       w_req_vl;
  logic [LANES*EW-1:0]                   w_lane_data;
  logic [LANES-1:0]                      w_lane_en;

  function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
    if (vl > VL_W'(VECTOR_MASK_LENGTH)) begin
      return VL_W'(VECTOR_MASK_LENGTH);
    end
    return vl;
  endfunction

  function automatic int elem_index(input logic [BEAT_W-1:0] beat, input int lane);
    return int'(beat) * LANES + lane;
  endfunction

  assign w_accept = (r_state == S_IDLE) && request_valid;
  assign w_req_vl = clamp_vl(request_vector_length);

  // Tail-undisturbed stops at the last beat holding a body element.
  always_comb begin
    if (TAIL_AGNOSTIC != 0) begin
      w_last_beat = BEAT_W'(BEATS - 1);
    end else begin
      w_last_beat = BEAT_W'((int'(r_vl) + LANES - 1) / LANES - 1);
    end
  end

  assign w_is_last = (r_beat == w_last_beat);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (request_valid) begin
          if ((w_req_vl == '0) && (TAIL_AGNOSTIC == 0)) begin
            w_next_state = S_COMPLETE;
          end else begin
            w_next_state = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (write_ready && w_is_last) begin
          w_next_state = S_COMPLETE;
        end
      end
      S_COMPLETE: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_beat <= '0;
      end else if ((r_state == S_WRITE) && write_ready && !w_is_last) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  // Captured result fields; only meaningful while the FSM is out of IDLE.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_dest    <= request_destination;
      r_vl      <= w_req_vl;
      r_mask_en <= request_mask_enable;
      r_mask    <= request_mask;
      r_data    <= request_data;
    end
  end

  always_comb begin
    w_lane_data = '0;
    w_lane_en   = '0;
    if (r_state == S_WRITE) begin
      for (int j = 0; j < LANES; j++) begin
        if (elem_index(r_beat, j) >= int'(r_vl)) begin
          if (TAIL_AGNOSTIC != 0) begin
            w_lane_en[j]            = 1'b1;
            w_lane_data[j*EW +: EW] = '1;
          end
        end else if (!r_mask_en || r_mask[elem_index(r_beat, j)]) begin
          w_lane_en[j]            = 1'b1;
          w_lane_data[j*EW +: EW] = r_data[elem_index(r_beat, j)*EW +: EW];
        end
      end
    end
  end

  assign request_ready        = (r_state == S_IDLE);
  assign write_valid          = (r_state == S_WRITE);
  assign write_destination    = (r_state == S_WRITE) ? r_dest : '0;
  assign write_beat_index     = (r_state == S_WRITE) ? r_beat : '0;
  assign write_data           = w_lane_data;
  assign write_element_enable = w_lane_en;
  assign complete_valid       = (r_state == S_COMPLETE);
  assign complete_destination = (r_state == S_COMPLETE) ? r_dest : '0;

endmodule

// File: doc/vector_writeback_sequencer.md
Name: vector_writeback_sequencer

Overview:
Write-back stage controller that drains one completed vector result into the vector register file over several beats of LANES elements each. It applies tail encoding (elements at index >= vl) and the optional execution mask to produce per-element write enables. It also trims or fills tail beats according to the tail policy. It sits between the execute-result buffer and the register-file write port, and signals completion to the scoreboard.

Parameters:
VECTOR_MASK_LENGTH, 8, number of elements per vector register (power of two, >= LANES)
ELEMENT_WIDTH, 32, bits per element
LANES, 2, elements written per beat (power of two, divides VECTOR_MASK_LENGTH)
REGISTER_INDEX_WIDTH, 5, width of destination register index
TAIL_AGNOSTIC, 0, 0 = tail undisturbed, 1 = tail agnostic (write all-ones)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
request_valid  in  1  result available
request_ready  out  1  sequencer can accept a result
request_destination  in  REGISTER_INDEX_WIDTH  destination vector register
request_vector_length  in  $clog2(VECTOR_MASK_LENGTH)+1  vl, 0..VECTOR_MASK_LENGTH; larger values clamp
request_mask_enable  in  1  1 = masked operation (vm=0 semantics)
request_mask  in  VECTOR_MASK_LENGTH  execution mask, bit i = element i
request_data  in  VECTOR_MASK_LENGTH*ELEMENT_WIDTH  element i at bits [i*EW +: EW]
write_valid  out  1  beat valid to register file
write_ready  in  1  register file accepts beat
write_destination  out  REGISTER_INDEX_WIDTH  captured destination
write_beat_index  out  $clog2(VECTOR_MASK_LENGTH/LANES)  beat number (0 if a single beat)
write_data  out  LANES*ELEMENT_WIDTH  beat data, lane j = element beat*LANES+j
write_element_enable  out  LANES  per-lane write enable
complete_valid  out  1  one-cycle pulse: result fully written
complete_destination  out  REGISTER_INDEX_WIDTH  register just completed

Behaviour:
- Reset: state IDLE, request_ready=1, write_valid=0, complete_valid=0, all data, index, enable and destination outputs 0. Reset mid-operation drops the captured result with no completion pulse.
- States: IDLE, WRITE, COMPLETE.
- IDLE: request_ready=1. On request_valid, capture all request fields, with vl clamped to VECTOR_MASK_LENGTH, and set beat counter to 0.
  - vl=0 and TAIL_AGNOSTIC=0 -> COMPLETE.
  - Otherwise -> WRITE.
- WRITE: request_ready=0, write_valid=1, outputs driven from registers and held stable while write_ready=0. On write_ready=1 the beat is accepted.
  - If the beat is the last beat, go to COMPLETE; otherwise increment the beat counter.
- Last beat:
  - TAIL_AGNOSTIC=1: beat VECTOR_MASK_LENGTH/LANES-1.
  - TAIL_AGNOSTIC=0: beat ceil(vl/LANES)-1. Beats lying wholly in the tail are never issued.
- COMPLETE: complete_valid=1 and complete_destination=captured destination for exactly one cycle -> IDLE. Minimum request-to-request spacing is beats+2 cycles; there is no back-to-back acceptance.
- Element i classification:
  - Tail: i >= vl.
  - Active: not tail and (request_mask_enable=0 or mask[i]=1).
  - Inactive: not tail and not active.
- Lane enable and data:
  - Active: enable=1, data=captured element.
  - Inactive: enable=0 (mask undisturbed), data=0.
  - Tail, TAIL_AGNOSTIC=0: enable=0, data=0.
  - Tail, TAIL_AGNOSTIC=1: enable=1, data all ones.
- A beat whose enables are all 0, but which is not wholly tail, is still issued.
- write_ready while write_valid=0 is ignored. request_valid is ignored outside IDLE.

Test Plan:
Defaults (VML=8, LANES=2, EW=32, TA=0) unless stated; write_ready=1 unless stated.
1. vl=8, mask_enable=0, dest=3 -> beats 0..3 on 4 consecutive cycles, enables 2'b11 each; complete_valid pulse with destination 3 on the next cycle; request_ready back to 1 the cycle after.
2. vl=5, mask_enable=0 -> only beats 0,1,2 issued; beat2 enable 2'b01, lane1 data 0; complete after beat 2.
3. vl=8, mask_enable=1, mask=8'hA5 -> enables beat0=01, beat1=01, beat2=10, beat3=10; inactive lanes carry data 0.
4. write_ready=0 for 3 cycles during beat 1 -> write_valid, write_beat_index=1, data and enables stable for those cycles; beat 2 appears only after write_ready=1.
5. vl=0 (TA=0) -> no write_valid ever; complete_valid one cycle after acceptance. Also: TA=1, vl=3 -> 4 beats; beat1 enables 11 with lane1=32'hFFFFFFFF; beats 2 and 3 all ones with enables 11.
6. reset asserted during beat 2 -> next cycle write_valid=0, request_ready=1, complete_valid never pulses; a new request (vl=2) then completes normally in 1 beat.
